// File: rtl/tmec_decode_buffer.sv
// Decoder data buffer: keeps the data bits of up to two codewords, drops parity bits on the
// way in, and XORs each bit with the Chien-search error flag on the way out.
// Optional feature: define TMEC_BUF_ERRCNT_EN to add the per-codeword err_count output.
module tmec_decode_buffer #(
  parameter int unsigned N = 15,
  parameter int unsigned K = 5,
  parameter int unsigned T = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic                       err,
  output logic                       dout,
  output logic                       dout_valid,
  output logic [$clog2(2*K+1)-1:0]   level,
  output logic                       overflow,
  output logic                       underflow
`ifdef TMEC_BUF_ERRCNT_EN
  ,
  output logic [$clog2(T+2)-1:0]     err_count
`endif
);

  localparam int unsigned Depth = 2 * K;
  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned LvlW  = $clog2(Depth + 1);
  localparam int unsigned PosW  = (N > 1) ? $clog2(N) : 1;

  logic [Depth-1:0] mem_q;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             dout_q, dout_d, dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             store_req, wr_acc, rd_acc;

  // Accept/reject decisions, pointer and level next-state.
  always_comb begin
    store_req = wr_en && (pos_q < PosW'(K));
    rd_acc    = rd_en && (level_q != '0);
    // A full buffer still takes a write when a read frees a slot in the same cycle.
    wr_acc    = store_req && ((level_q != LvlW'(Depth)) || rd_acc);

    pos_d = pos_q;
    if (wr_en) pos_d = (pos_q == PosW'(N - 1)) ? '0 : pos_q + 1'b1;

    wr_ptr_d = wr_ptr_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;

    rd_ptr_d = rd_ptr_q;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;

    level_d = level_q;
    if (wr_acc && !rd_acc) level_d = level_q + 1'b1;
    else if (rd_acc && !wr_acc) level_d = level_q - 1'b1;

    dout_d       = rd_acc ? (mem_q[rd_ptr_q] ^ err) : 1'b0;
    dout_valid_d = rd_acc;
    overflow_d   = overflow_q || (store_req && !wr_acc);
    underflow_d  = underflow_q || (rd_en && !rd_acc);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

`ifdef TMEC_BUF_ERRCNT_EN
  localparam int unsigned EcW  = $clog2(T + 2);
  localparam int unsigned RdnW = (K > 1) ? $clog2(K) : 1;

  logic [EcW-1:0]  ec_cnt_q, ec_cnt_d, ec_sum, err_count_q, err_count_d;
  logic [RdnW-1:0] rd_num_q, rd_num_d;

  // Running error total, saturating at T+1; captured and cleared on the K-th read.
  always_comb begin
    ec_sum      = (ec_cnt_q == EcW'(T + 1)) ? ec_cnt_q : ec_cnt_q + EcW'(err);
    ec_cnt_d    = ec_cnt_q;
    rd_num_d    = rd_num_q;
    err_count_d = err_count_q;
    if (rd_acc) begin
      if (rd_num_q == RdnW'(K - 1)) begin
        err_count_d = ec_sum;
        ec_cnt_d    = '0;
        rd_num_d    = '0;
      end else begin
        ec_cnt_d = ec_sum;
        rd_num_d = rd_num_q + 1'b1;
      end
    end
  end

  // Error counter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ec_cnt_q    <= '0;
      rd_num_q    <= '0;
      err_count_q <= '0;
    end else begin
      ec_cnt_q    <= ec_cnt_d;
      rd_num_q    <= rd_num_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_tmec_decode_buffer.sv
// Directed bench for tmec_decode_buffer (default N=15, K=5, T=3).
module tb_tmec_decode_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       din = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err = 1'b0;
  logic       dout, dout_valid, overflow, underflow;
  logic [3:0] level;
`ifdef TMEC_BUF_ERRCNT_EN
  logic [2:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  tmec_decode_buffer #(.N(15), .K(5), .T(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .err        (err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef TMEC_BUF_ERRCNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the rising edge.
  task automatic cyc(input logic w, input logic d, input logic r, input logic e);
    wr_en = w; din = d; rd_en = r; err = e;
    @(posedge clk);
    #1;
    wr_en = 1'b0; din = 1'b0; rd_en = 1'b0; err = 1'b0;
  endtask

  // One full codeword: data[0] first, parity bits all 1.
  task automatic wr_word(input logic [4:0] data);
    for (int i = 0; i < 15; i++) cyc(1'b1, (i < 5) ? data[i] : 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rd_word(input string tag, input logic [4:0] errs, input logic [4:0] exp);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, errs[i]);
      chk({tag, "_valid"}, dout_valid, 1'b1);
      chk({tag, "_dout"}, dout, exp[i]);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk("rst_level_async", level, 4'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", level, 4'd0);
    chk("rst_dout", dout, 1'b0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_udf", underflow, 1'b0);
`ifdef TMEC_BUF_ERRCNT_EN
    chk("rst_errcnt", err_count, 3'd0);
`endif
    reset = 1'b1;

    // One codeword in, parity discarded
    wr_word(5'b01101);
    chk("cw1_level", level, 4'd5);
    chk("cw1_ovf", overflow, 1'b0);

    // Read back with corrections: 1^0,0^1,1^0,1^0,0^1
    rd_word("cw1_rd", 5'b10010, 5'b11111);
    chk("cw1_level_empty", level, 4'd0);
`ifdef TMEC_BUF_ERRCNT_EN
    chk("cw1_errcnt", err_count, 3'd2);
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_valid", dout_valid, 1'b0);
    chk("idle_dout", dout, 1'b0);

    // Empty read
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("udf_flag", underflow, 1'b1);
    chk("udf_valid", dout_valid, 1'b0);
    chk("udf_level", level, 4'd0);

    // Error counting: 3 errors, then saturation
    wr_word(5'b10011);
    rd_word("ec1_rd", 5'b01101, 5'b11110);
`ifdef TMEC_BUF_ERRCNT_EN
    chk("ec1_errcnt", err_count, 3'd3);
`endif
    wr_word(5'b01010);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
`ifdef TMEC_BUF_ERRCNT_EN
    chk("ec2_errcnt_hold", err_count, 3'd3);
`endif
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ec2_last_dout", dout, 1'b1);
`ifdef TMEC_BUF_ERRCNT_EN
    chk("ec2_errcnt_sat", err_count, 3'd4);
`endif
    chk("udf_sticky", underflow, 1'b1);

    // Full buffer with simultaneous read and write
    pulse_reset();
    chk("rst_udf_clear", underflow, 1'b0);
    wr_word(5'b11001);
    wr_word(5'b10110);
    chk("full_level", level, 4'd10);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("full_rw_level", level, 4'd10);
    chk("full_rw_ovf", overflow, 1'b0);
    chk("full_rw_dout", dout, 1'b1);
    chk("full_rw_valid", dout_valid, 1'b1);

    // Overflow on the third codeword's first data bit
    pulse_reset();
    wr_word(5'b11001);
    wr_word(5'b10110);
    chk("ovf_pre_level", level, 4'd10);
    chk("ovf_pre_flag", overflow, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_level", level, 4'd10);
    for (int i = 1; i < 15; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_level_end", level, 4'd10);
    rd_word("ovf_rdA", 5'b00000, 5'b11001);
    rd_word("ovf_rdB", 5'b00000, 5'b10110);
    chk("ovf_level_drained", level, 4'd0);
    chk("ovf_sticky", overflow, 1'b1);

    // Reset mid-codeword restarts the position counter
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_level", level, 4'd5);
    pulse_reset();
    chk("mid_ovf_clear", overflow, 1'b0);
    wr_word(5'b10111);
    chk("mid_level_after", level, 4'd5);
    rd_word("mid_rd", 5'b00000, 5'b10111);

    // Empty with simultaneous write and read: no bypass
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("erw_level", level, 4'd1);
    chk("erw_udf", underflow, 1'b1);
    chk("erw_valid", dout_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("erw_rd_valid", dout_valid, 1'b1);
    chk("erw_rd_dout", dout, 1'b1);
    chk("erw_level_end", level, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmec_decode_buffer.md
TMEC_DECODE_BUFFER -- requirements
Module: tmec_decode_buffer

Interface
REQ-001 Parameter N, default 15: codeword length in bits.
REQ-002 Parameter K, default 5: data bits per codeword, K < N.
REQ-003 Parameter T, default 3: correctable errors; sets the width of err_count.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 din  input  1  received serial bit.
REQ-007 wr_en  input  1  din valid this cycle (the control block's bufCe).
REQ-008 rd_en  input  1  release one corrected data bit (the control block's vdout1).
REQ-009 err  input  1  Chien-search error flag, aligned with rd_en.
REQ-010 dout  output  1  corrected data bit.
REQ-011 dout_valid  output  1  dout qualifier.
REQ-012 level  output  $clog2(2*K+1)  stored bit count.
REQ-013 overflow  output  1  sticky: a write was dropped.
REQ-014 underflow  output  1  sticky: a read hit an empty buffer.
REQ-015 err_count  output  $clog2(T+2)  corrected bits in the last codeword; present only with TMEC_BUF_ERRCNT_EN.

Function
REQ-016 Storage: circular bit buffer, DEPTH = 2*K, holding two codewords' data portions.
REQ-017 Position counter pos: counts 0..N-1 on each wr_en; wraps N-1 -> 0.
REQ-018 Write: a wr_en bit is stored only when pos < K; parity bits (pos >= K) only advance pos.
REQ-019 Write pointer: wraps DEPTH-1 -> 0.
REQ-020 Read: rd_en pops one bit at the read pointer; read pointer wraps DEPTH-1 -> 0.
REQ-021 Read output: dout = stored bit XOR err, registered; dout_valid = 1 exactly one cycle after an accepted rd_en.
REQ-022 Read latency: exactly 1 cycle; the first bit written reaches dout no earlier than 2 cycles after its wr_en.
REQ-023 Output idle: when no read is accepted, dout = 0 and dout_valid = 0 on the next cycle.
REQ-024 Full, write only: a storing write at level == DEPTH is dropped, overflow is set, and pos still advances.
REQ-025 Full, simultaneous read and write: both are accepted and level is unchanged.
REQ-026 Empty read: rd_en at level == 0 (with no same-cycle write) leaves pointers unchanged, sets underflow, and gives dout_valid = 0.
REQ-027 Empty, simultaneous write and read: the write is stored, the read is rejected, underflow is set, level becomes 1 (no bypass).
REQ-028 Level update: level += accepted write, -= accepted read, never outside 0..DEPTH.
REQ-029 Sticky flags: overflow and underflow clear only on reset.

Reset
REQ-030 Reset asserted (reset = 0): pos, both pointers and level become 0; dout, dout_valid, overflow, underflow and err_count become 0; buffer contents need not be cleared.
REQ-031 Reset mid-codeword: discards all stored bits; the next wr_en after release is treated as pos = 0.
REQ-032 Reset release: deassertion takes effect synchronously and the first edge after deassertion operates normally.

Configuration
REQ-033 Macro TMEC_BUF_ERRCNT_EN enables the error counter.
REQ-034 With TMEC_BUF_ERRCNT_EN defined: an internal counter adds 1 per accepted read with err = 1 and counts reads modulo K.
REQ-035 Counter capture: on the K-th read of a codeword, err_count loads the final total (including that read) and the internal counter clears.
REQ-036 Counter saturation: the internal counter saturates at T+1.
REQ-037 Without TMEC_BUF_ERRCNT_EN: the err_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-038 Bench shall cover: reset low, then 15 wr_en cycles with din=1,0,1,1,0 then ten 1s, no rd_en -> level = 5 and overflow = 0.
REQ-039 Bench shall cover: after REQ-038, 5 rd_en with err=0,1,0,0,1 -> dout = 1,1,1,1,1, each one cycle after rd_en, and level = 0.
REQ-040 Bench shall cover: three codewords written with no reads -> level = 10 after the second; the first data bit of the third sets overflow and level stays 10.
REQ-041 Bench shall cover: rd_en at level 0 -> underflow = 1, dout_valid = 0; at level 10, simultaneous write and read -> level stays 10 and overflow stays 0.
REQ-042 Bench shall cover: reset pulsed after 7 writes -> level = 0 immediately; the next 15 writes store exactly 5 bits.
REQ-043 Bench shall cover, with TMEC_BUF_ERRCNT_EN: 5 reads with err=1,0,1,1,0 -> err_count = 3 one cycle after the fifth read; a codeword with 5 errors -> err_count = 4 (saturated).
